// File: rtl/present_ctrl_pkg.sv
// Shared constants and state encoding for the PRESENT-80 byte-serial host controller.
// Byte counts for key and plaintext, the command bit that requests a new key,
// and the counter terminal values derived from them.
package present_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_PT,
    ST_START,
    ST_RUN,
    ST_OUT
  } state_t;

  localparam int KEY_BYTES      = 10;
  localparam int PT_BYTES       = 8;
  localparam int CT_BYTES       = 8;
  localparam int CMD_NEWKEY_BIT = 0;

  // Terminal values of the 4-bit byte counter
  localparam logic [3:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0] PT_LAST  = 4'(PT_BYTES - 1);
  localparam logic [3:0] OUT_LAST = 4'(CT_BYTES - 1);

endpackage

// File: rtl/byte_shift_reg.sv
// Register of W bits that shifts one byte in at the LSB end (MSB-first streams)
// or loads a full word in parallel; the MSB byte is the next byte to leave.
// Parallel load wins over a shift in the same cycle.
module byte_shift_reg #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  input  logic         i_load,
  input  logic [W-1:0] i_load_dat,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load, shift-in, or hold; synchronous clear on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_dat;
    end else if (i_shift) begin
      r_q <= {r_q[W-9:0], i_byte};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/present_byte_ctrl.sv
// Byte-serial host controller: collects cmd/key/plaintext, starts the PRESENT core,
// returns the 64-bit ciphertext as 8 bytes MSB first.
// All handshake outputs are registered; OUT holds its byte while the host stalls.
module present_byte_ctrl
  import present_ctrl_pkg::*;
(
  input  logic        Clk_ik,
  input  logic        Reset_ir,
  input  logic [7:0]  InData_ib,
  input  logic        InValid_i,
  output logic        InReady_o,
  output logic [7:0]  OutData_ob,
  output logic        OutValid_o,
  input  logic        OutReady_i,
  output logic [79:0] Key_ob,
  output logic [63:0] PlainText_ob,
  output logic        Start_o,
  input  logic        Ready_i,
  input  logic [63:0] CipherText_ib,
  output logic        Busy_o
);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_in_rdy;
  logic        r_out_vld;
  logic        r_start;
  logic        r_busy;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_key_shift;
  logic        w_pt_shift;
  logic        w_ct_load;
  logic [63:0] w_ct_q;

  assign w_in_xfer   = r_in_rdy & InValid_i;
  assign w_out_xfer  = r_out_vld & OutReady_i;
  assign w_key_shift = w_in_xfer && (r_state == ST_KEY);
  assign w_pt_shift  = w_in_xfer && (r_state == ST_PT);
  assign w_ct_load   = (r_state == ST_RUN) && Ready_i;

  byte_shift_reg #(.W(80)) u_key_sr (
    .i_clk      (Clk_ik),
    .i_rst      (Reset_ir),
    .i_shift    (w_key_shift),
    .i_byte     (InData_ib),
    .i_load     (1'b0),
    .i_load_dat (80'd0),
    .o_q        (Key_ob)
  );

  byte_shift_reg #(.W(64)) u_pt_sr (
    .i_clk      (Clk_ik),
    .i_rst      (Reset_ir),
    .i_shift    (w_pt_shift),
    .i_byte     (InData_ib),
    .i_load     (1'b0),
    .i_load_dat (64'd0),
    .o_q        (PlainText_ob)
  );

  // Ciphertext register: loaded from the core, then emptied MSB byte first
  byte_shift_reg #(.W(64)) u_ct_sr (
    .i_clk      (Clk_ik),
    .i_rst      (Reset_ir),
    .i_shift    (w_out_xfer),
    .i_byte     (8'h00),
    .i_load     (w_ct_load),
    .i_load_dat (CipherText_ib),
    .o_q        (w_ct_q)
  );

  // Frame sequencer with registered handshake, start and busy outputs
  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_xfer) begin
            r_cnt  <= 4'd0;
            r_busy <= 1'b1;
            r_state <= InData_ib[CMD_NEWKEY_BIT] ? ST_KEY : ST_PT;
          end
        end
        ST_KEY: begin
          if (w_in_xfer) begin
            if (r_cnt == KEY_LAST) begin
              r_cnt   <= 4'd0;
              r_state <= ST_PT;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_PT: begin
          if (w_in_xfer) begin
            if (r_cnt == PT_LAST) begin
              r_cnt    <= 4'd0;
              r_state  <= ST_START;
              r_in_rdy <= 1'b0;
              r_start  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_START: begin
          // An idle core takes the start in this cycle; a busy one makes us wait
          if (Ready_i) begin
            r_state <= ST_RUN;
            r_start <= 1'b0;
          end
        end
        ST_RUN: begin
          if (Ready_i) begin
            r_cnt     <= 4'd0;
            r_state   <= ST_OUT;
            r_out_vld <= 1'b1;
          end
        end
        ST_OUT: begin
          if (w_out_xfer) begin
            if (r_cnt == OUT_LAST) begin
              r_state   <= ST_IDLE;
              r_out_vld <= 1'b0;
              r_in_rdy  <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= 4'd0;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
          r_start   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign InReady_o  = r_in_rdy;
  assign OutValid_o = r_out_vld;
  assign OutData_ob = w_ct_q[63:56];
  assign Start_o    = r_start;
  assign Busy_o     = r_busy;

endmodule
